// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 FSM states, command bytes and default timing
package ps2_pkg;

  typedef logic [2:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE      = 3'd0;
  localparam ps2_state_t ST_INHIBIT   = 3'd1;
  localparam ps2_state_t ST_RTS       = 3'd2;
  localparam ps2_state_t ST_WAIT_CLK  = 3'd3;
  localparam ps2_state_t ST_DATA      = 3'd4;
  localparam ps2_state_t ST_WAIT_IDLE = 3'd5;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;
  localparam logic [7:0] RESEND_BYTE  = 8'hFE;

  // 50 MHz system clock: 120 us inhibit, 15 ms device watchdog
  localparam int DEF_INHIBIT_CYCLES = 6000;
  localparam int DEF_TIMEOUT_CYCLES = 750000;
  localparam int DEF_SYNC_STAGES    = 2;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - pad synchronizer with falling-edge detect, shared with the receiver
module ps2_sync_edge
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Reset to the pulled-up idle level so leaving reset never fakes an edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign fall = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Optional PS2_TX_RETRY_EN: one silent retry from INHIBIT before tx_error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  ps2_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       nfall;
  logic [7:0]       data_r;
  logic             parity_r;
  logic             bit_low;
  logic             clk_sync, clk_fall, dat_sync, dat_fall_unused;
  logic             watched, done_now, expired, nack, fail, restart;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (ps2_clk_in),
    .sync   (clk_sync),
    .fall   (clk_fall)
  );

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dat_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (ps2_dat_in),
    .sync   (dat_sync),
    .fall   (dat_fall_unused)
  );

  assign watched  = (state == ST_WAIT_CLK) || (state == ST_DATA) || (state == ST_WAIT_IDLE);
  assign done_now = (state == ST_WAIT_IDLE) && clk_sync && dat_sync;
  // A device edge in the expiry cycle still counts as progress
  assign expired  = watched && !clk_fall && !done_now && (cnt == TO_LIMIT);
  assign nack     = (state == ST_DATA) && clk_fall && (nfall == 4'd10) && dat_sync;
  assign fail     = expired || nack;

`ifdef PS2_TX_RETRY_EN
  logic attempt;
  assign restart = fail && !attempt;
`else
  assign restart = 1'b0;
`endif

  assign tx_ready   = (state == ST_IDLE);
  assign busy       = !tx_ready;
  assign tx_done    = done_now;
  assign tx_error   = fail && !restart;
  assign ps2_clk_oe = (state == ST_INHIBIT) || (state == ST_RTS);
  assign ps2_dat_oe = (state == ST_RTS) || (state == ST_WAIT_CLK) || ((state == ST_DATA) && bit_low);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      nfall    <= '0;
      data_r   <= '0;
      parity_r <= 1'b0;
      bit_low  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      attempt  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            data_r   <= tx_data;
            parity_r <= odd_parity(tx_data);
            cnt      <= '0;
            state    <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt   <= '0;
            state <= ST_RTS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RTS: begin
          cnt   <= '0;
          nfall <= '0;
          state <= ST_WAIT_CLK;
        end
        default: begin
          cnt <= cnt + 1'b1;
          if (done_now) begin
            cnt   <= '0;
            state <= ST_IDLE;
`ifdef PS2_TX_RETRY_EN
            attempt <= 1'b0;
`endif
          end else if (restart) begin
            cnt     <= '0;
            bit_low <= 1'b0;
            state   <= ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
            attempt <= 1'b1;
`endif
          end else if (fail) begin
            cnt     <= '0;
            bit_low <= 1'b0;
            state   <= ST_IDLE;
`ifdef PS2_TX_RETRY_EN
            attempt <= 1'b0;
`endif
          end else if (clk_fall) begin
            cnt <= '0;
            if (state != ST_WAIT_IDLE) begin
              // nfall counts edges already seen; this edge selects the next bit
              nfall <= nfall + 4'd1;
              state <= (nfall == 4'd10) ? ST_WAIT_IDLE : ST_DATA;
              if (nfall < 4'd8) begin
                bit_low <= ~data_r[nfall[2:0]];
              end else if (nfall == 4'd8) begin
                bit_low <= ~parity_r;
              end else begin
                bit_low <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int TO   = 300;
  localparam int HALF = 25;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_line),
    .ps2_dat_in (ps2_dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  always #5 clk = ~clk;

  // kind: 0 = device ACKs, 1 = device NACKs, 2 = device never clocks
  typedef struct {
    logic [7:0] data;
    int         kind;
    int         attempts;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         n_rts = 0;
  int         rts_base = 0;
  int         inh_len = 0;
  int         release_cyc = 0;
  int         dev_falls = 0;
  int         dev_mode = 0;
  bit         dev_abort = 1'b0;
  logic       prev_clk_oe = 1'b0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_par = 1'b0;
  logic       cap_stop = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic int attempts_for(input int kind);
`ifdef PS2_TX_RETRY_EN
    return (kind == 0) ? 1 : 2;
`else
    return 1;
`endif
  endfunction

  // Monitor: inhibit length, RTS count, WAIT_CLK entry time, and scoreboard pops on pulses
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (ps2_clk_oe && !ps2_dat_oe) begin
        inh_len++;
      end else begin
        if (ps2_clk_oe && ps2_dat_oe) begin
          check("inhibit_len", inh_len, INH);
          n_rts++;
        end
        inh_len = 0;
      end
      if (prev_clk_oe && !ps2_clk_oe) release_cyc = cyc;
      prev_clk_oe = ps2_clk_oe;
      if (tx_done || tx_error) begin
        check("done_error_exclusive", {31'd0, tx_done & tx_error}, 0);
        check("ready_low_at_pulse", {31'd0, tx_ready}, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("error_vs_done", {31'd0, tx_error}, (e.kind != 0) ? 1 : 0);
          check("attempts", n_rts - rts_base, e.attempts);
          rts_base = n_rts;
          if (e.kind == 2) begin
            check("timeout_latency", cyc - release_cyc, TO);
          end else begin
            check("frame_data", {24'd0, cap_data}, {24'd0, e.data});
            check("frame_parity", {31'd0, cap_par}, (($countones(e.data) % 2) == 0) ? 1 : 0);
            check("frame_stop", {31'd0, cap_stop}, 1);
          end
        end
        @(negedge clk);
        cyc++;
        inh_len = 0;
        prev_clk_oe = ps2_clk_oe;
        check("pulse_one_cycle", {31'd0, tx_done | tx_error}, 0);
        check("lines_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
        check("ready_after_pulse", {31'd0, tx_ready}, 1);
      end
    end
  end

  task automatic hold(input int n);
    for (int i = 0; i < n && !dev_abort; i++) @(negedge clk);
  endtask

  // Device model: clocks 11 falls, samples DAT late in each low phase, ACK/NACK on the 11th
  initial begin
    logic [10:0] bits;
    forever begin
      @(negedge clk);
      if (resetn && ps2_clk_line && !ps2_dat_line && !dev_abort) begin
        if (dev_mode == 2) begin
          while (ps2_clk_line && !ps2_dat_line) @(negedge clk);
        end else begin
          bits = '0;
          for (int k = 1; k <= 11 && !dev_abort; k++) begin
            if (k == 11) dev_dat_low = (dev_mode == 0);
            hold(HALF);
            dev_clk_low = 1'b1;
            dev_falls++;
            hold(HALF - 2);
            if (k <= 10) bits[k] = ps2_dat_line;
            if (k == 10) begin
              cap_data = bits[8:1];
              cap_par  = bits[9];
              cap_stop = bits[10];
            end
            hold(2);
            dev_clk_low = 1'b0;
          end
          hold(HALF);
          dev_dat_low = 1'b0;
          dev_clk_low = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input int kind, input bit keep_valid);
    exp_t e;
    int   budget;
    dev_mode = kind;
    tx_data  = d;
    tx_valid = 1'b1;
    budget   = 0;
    while (!tx_ready && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    if (!tx_ready) begin
      check("accept_wait", 0, 1);
    end else begin
      e.data = d;
      e.kind = kind;
      e.attempts = attempts_for(kind);
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (!keep_valid) tx_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    repeat (2 * HALF + 5) @(negedge clk);
  endtask

  initial begin
    int base;
    int budget;
    repeat (4) @(negedge clk);
    check("rst_ready", {31'd0, tx_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    check("rst_pulses", {30'd0, tx_done, tx_error}, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    send(8'hED, 0, 1'b0); drain();
    send(8'h00, 0, 1'b0); drain();
    send(8'h01, 0, 1'b0); drain();
    for (int i = 0; i < 5; i++) begin
      send(8'($urandom_range(0, 255)), 0, 1'b0);
      drain();
    end
    send(8'($urandom_range(0, 255)), 1, 1'b0); drain();
    send(8'($urandom_range(0, 255)), 2, 1'b0); drain();

    // Reset in the middle of a byte, a few cycles after the fourth device fall
    base = dev_falls;
    send(8'hA5, 0, 1'b0);
    budget = 0;
    while (dev_falls < base + 4 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check("mid_byte_reached", (dev_falls >= base + 4) ? 1 : 0, 1);
    repeat (6) @(negedge clk);
    exp_q.delete();
    dev_abort = 1'b1;
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    check("midrst_ready", {31'd0, tx_ready}, 1);
    check("midrst_pulses", {30'd0, tx_done, tx_error}, 0);
    resetn = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    dev_abort = 1'b0;
    rts_base = n_rts;

    // tx_valid held through a transfer with a different byte waiting
    send(8'h3C, 0, 1'b1);
    tx_data = 8'hC3;
    send(8'hC3, 0, 1'b0);
    drain();

    send(8'hF4, 0, 1'b0); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule
